// File: rtl/lsu_mem_bridge_pkg.sv
// Shared definitions for the LSU-to-memory bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Encoding of the LSU 'wr' input.
  localparam logic LOAD  = 1'b1;
  localparam logic STORE = 1'b0;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/lsu_mem_bridge_if.sv
// Memory-side bus of the bridge: request channel (valid/ready) and response strobe.
// Latency: n/a (wiring only).
// Backpressure: the request is held by the master until mem_req_ready; responses cannot be stalled.
// Ports: master = bridge (drives request, samples response); slave = memory.
interface lsu_mem_bridge_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_strb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_strb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_strb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

endinterface

// File: rtl/lsu_mem_bridge.sv
// Bridges one LSU M-stage access at a time onto a valid/ready memory bus with timeout.
// Latency: 4 cycles minimum for a bus access (capture, REQ, WAIT, DONE); 2 for an empty store.
// Backpressure: holds the request while mem_req_ready=0; stalls the pipeline until DONE.
// Ports: clk, rst_n (sync, active-low); LSU side cs (active-low), wr, mask, addr, data_wr,
//        data_rd, stall, access_fault; memory side via lsu_mem_bridge_if.master.
module lsu_mem_bridge
  import lsu_mem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cs,
  input  logic                    wr,
  input  logic [3:0]              mask,
  input  logic [31:0]             addr,
  input  logic [31:0]             data_wr,
  output logic [31:0]             data_rd,
  output logic                    stall,
  output logic                    access_fault,
  lsu_mem_bridge_if.master        mem
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The counter is still at TIMEOUT_CYCLES-2 in the last cycle an access may
  // spend in REQ/WAIT; it would reach TIMEOUT_CYCLES-1 on the abort edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_q;
  logic [3:0]       mask_q;
  logic [31:2]      addr_q;
  logic [31:0]      wdata_q;
  logic             timeout;
  logic             empty_store;

  // Byte-lane offset is resolved by the LSU; the bus only sees word addresses.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr[1:0];

  assign timeout     = (cnt_q == CNT_LAST);
  assign empty_store = (wr == STORE) && (mask == 4'b0000);

  // Combinational so the requesting instruction freezes in its first cycle.
  assign stall = ((state_q == ST_IDLE) && !cs) || (state_q == ST_REQ) || (state_q == ST_WAIT);

  // Request fields come straight from the capture registers, so they are
  // stable for the whole REQ phase.
  assign mem.mem_req_valid = (state_q == ST_REQ);
  assign mem.mem_req_we    = ~wr_q;
  assign mem.mem_req_addr  = {addr_q, 2'b00};
  assign mem.mem_req_wdata = wdata_q;
  assign mem.mem_req_strb  = (wr_q == LOAD) ? 4'b1111 : mask_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      data_rd      <= '0;
      access_fault <= 1'b0;
      wr_q         <= LOAD;
      mask_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      access_fault <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!cs) begin
            if (empty_store) begin
              state_q <= ST_DONE;
            end else begin
              wr_q    <= wr;
              mask_q  <= mask;
              addr_q  <= addr[31:2];
              wdata_q <= data_wr;
              cnt_q   <= '0;
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          // Abort wins over a same-cycle ready: the request is abandoned and
          // any response it might still produce lands outside WAIT.
          if (timeout) begin
            data_rd      <= '0;
            access_fault <= 1'b1;
            state_q      <= ST_DONE;
          end else if (mem.mem_req_ready) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // A response in the final allowed cycle still completes normally.
          if (mem.mem_rsp_valid) begin
            data_rd      <= mem.mem_rsp_err ? 32'h0 : mem.mem_rsp_rdata;
            access_fault <= mem.mem_rsp_err;
            state_q      <= ST_DONE;
          end else if (timeout) begin
            data_rd      <= '0;
            access_fault <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
module tb_lsu_mem_bridge;
  import lsu_mem_bridge_pkg::*;

  localparam int T = 8;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        stall;
  logic        access_fault;

  lsu_mem_bridge_if bus ();

  lsu_mem_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs           (cs),
    .wr           (wr),
    .mask         (mask),
    .addr         (addr),
    .data_wr      (data_wr),
    .data_rd      (data_rd),
    .stall        (stall),
    .access_fault (access_fault),
    .mem          (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state and per-access expectations.
  logic [31:0] model_data = 32'h0;
  int          exp_done;
  int          exp_valid_cycles;
  logic        exp_fault;
  logic [31:0] exp_data;

  // Observations of one access.
  int          obs_done, obs_stall_cycles, obs_valid_cycles, obs_fault_cycles, obs_hs_cycle;
  logic        obs_fault_at_done, obs_we, obs_unstable;
  logic [31:0] obs_data_at_done, obs_data_end, obs_addr, obs_wdata;
  logic [3:0]  obs_strb;

  // Timeline model: capture in cycle 0, request visible from cycle 1, ready
  // from cycle 1+rdy_dly, response rsp_dly cycles after the cycle following the
  // handshake. Anything not finished by cycle T-1 is aborted into DONE at cycle T.
  task automatic predict(input logic p_wr, input logic [3:0] p_mask, input int rdy_dly,
                         input int rsp_dly, input logic p_err, input logic [31:0] p_rdata);
    int hs, r;
    bit complete;
    if (p_wr == STORE && p_mask == 4'h0) begin
      exp_done = 1; exp_valid_cycles = 0; exp_fault = 1'b0; exp_data = model_data;
      return;
    end
    hs = (rdy_dly < 0) ? NEVER : 1 + rdy_dly;
    r  = (rsp_dly < 0 || hs > T - 1) ? NEVER : hs + 1 + rsp_dly;
    complete = (r <= T - 1);
    exp_done = complete ? r + 1 : T;
    exp_valid_cycles = (hs < T - 1) ? hs : T - 1;
    exp_fault = !complete || p_err;
    exp_data = (complete && !p_err) ? p_rdata : 32'h0;
    model_data = exp_data;
  endtask

  // Drives one LSU access and plays the memory; called right after a rising edge.
  task automatic run_access(input logic a_wr, input logic [3:0] a_mask, input logic [31:0] a_addr,
                            input logic [31:0] a_wdata, input int rdy_dly, input int rsp_dly,
                            input logic a_err, input logic [31:0] a_rdata);
    int hs_target, rsp_cycle;
    bit hs_seen, done_seen, first_valid;
    hs_target = (rdy_dly < 0) ? NEVER : 1 + rdy_dly;
    rsp_cycle = NEVER;
    hs_seen = 0; done_seen = 0; first_valid = 1;
    obs_done = -1; obs_stall_cycles = 0; obs_valid_cycles = 0; obs_fault_cycles = 0;
    obs_hs_cycle = -1; obs_unstable = 1'b0; obs_fault_at_done = 1'b0; obs_data_at_done = 32'h0;
    obs_addr = 32'h0; obs_wdata = 32'h0; obs_we = 1'b0; obs_strb = 4'h0;
    wr = a_wr; mask = a_mask; addr = a_addr; data_wr = a_wdata;
    for (int k = 0; k < 64; k++) begin
      cs = done_seen ? 1'b1 : 1'b0;
      bus.mem_req_ready = !hs_seen && (k >= hs_target);
      bus.mem_rsp_valid = (k == rsp_cycle);
      bus.mem_rsp_err   = (k == rsp_cycle) ? a_err : 1'($urandom_range(0, 1));
      bus.mem_rsp_rdata = (k == rsp_cycle) ? a_rdata : $urandom;
      @(negedge clk);
      if (stall) obs_stall_cycles++;
      if (access_fault) obs_fault_cycles++;
      if (bus.mem_req_valid) begin
        obs_valid_cycles++;
        if (first_valid) begin
          obs_addr = bus.mem_req_addr; obs_wdata = bus.mem_req_wdata;
          obs_we = bus.mem_req_we; obs_strb = bus.mem_req_strb; first_valid = 0;
        end else if (obs_addr !== bus.mem_req_addr || obs_wdata !== bus.mem_req_wdata ||
                     obs_we !== bus.mem_req_we || obs_strb !== bus.mem_req_strb) begin
          obs_unstable = 1'b1;
        end
        if (bus.mem_req_ready && !hs_seen) begin
          hs_seen = 1; obs_hs_cycle = k;
          rsp_cycle = (rsp_dly < 0) ? NEVER : k + 1 + rsp_dly;
        end
      end
      if (!done_seen && k > 0 && !stall) begin
        done_seen = 1; obs_done = k;
        obs_fault_at_done = access_fault; obs_data_at_done = data_rd;
      end
      obs_data_end = data_rd;
      @(posedge clk); #1;
      if (done_seen && (rsp_cycle == NEVER || k >= rsp_cycle)) break;
    end
    cs = 1'b1;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs = 1'b1; wr = LOAD; mask = 4'h0; addr = 32'h0; data_wr = 32'h0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = 32'h0; bus.mem_rsp_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (data_rd !== 32'h0) begin n_bad++; $display("FAIL reset_data_rd: got %h want 0", data_rd); end
    n_cmp++; if (access_fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", access_fault); end
    n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.mem_req_valid); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall_cs1: got %b want 0", stall); end
    cs = 1'b0; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL reset_stall_cs0: got %b want 1", stall); end
    cs = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    predict(LOAD, 4'h0, 0, 0, 1'b0, 32'hDEADBEEF);
    run_access(LOAD, 4'h0, 32'h100, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF);
    n_cmp++; if (obs_addr !== 32'h100) begin n_bad++; $display("FAIL load_addr: got %h want 100", obs_addr); end
    n_cmp++; if (obs_strb !== 4'hF) begin n_bad++; $display("FAIL load_strb: got %b want 1111", obs_strb); end
    n_cmp++; if (obs_we !== 1'b0) begin n_bad++; $display("FAIL load_we: got %b want 0", obs_we); end
    n_cmp++; if (obs_stall_cycles !== 3) begin n_bad++; $display("FAIL load_stall: got %0d want 3", obs_stall_cycles); end
    n_cmp++; if (obs_done !== exp_done) begin n_bad++; $display("FAIL load_done: got %0d want %0d", obs_done, exp_done); end
    n_cmp++; if (obs_data_at_done !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_data: got %h want deadbeef", obs_data_at_done); end
    n_cmp++; if (obs_fault_cycles !== 0) begin n_bad++; $display("FAIL load_fault: got %0d want 0", obs_fault_cycles); end
  endtask

  task automatic test_store_byte();
    predict(STORE, 4'b1000, 0, 0, 1'b0, 32'h5A5A0000);
    run_access(STORE, 4'b1000, 32'h203, 32'hAB000000, 0, 0, 1'b0, 32'h5A5A0000);
    n_cmp++; if (obs_addr !== 32'h200) begin n_bad++; $display("FAIL store_addr: got %h want 200", obs_addr); end
    n_cmp++; if (obs_we !== 1'b1) begin n_bad++; $display("FAIL store_we: got %b want 1", obs_we); end
    n_cmp++; if (obs_strb !== 4'b1000) begin n_bad++; $display("FAIL store_strb: got %b want 1000", obs_strb); end
    n_cmp++; if (obs_wdata !== 32'hAB000000) begin n_bad++; $display("FAIL store_wdata: got %h want ab000000", obs_wdata); end
    n_cmp++; if (obs_done !== 3) begin n_bad++; $display("FAIL store_done: got %0d want 3", obs_done); end
    n_cmp++; if (obs_fault_at_done !== 1'b0) begin n_bad++; $display("FAIL store_fault: got %b want 0", obs_fault_at_done); end
  endtask

  task automatic test_backpressure();
    predict(STORE, 4'b0110, 5, 0, 1'b0, 32'h01234567);
    run_access(STORE, 4'b0110, 32'h44, 32'h00FFEE00, 5, 0, 1'b0, 32'h01234567);
    n_cmp++; if (obs_valid_cycles !== 6) begin n_bad++; $display("FAIL bp_valid_cycles: got %0d want 6", obs_valid_cycles); end
    n_cmp++; if (obs_hs_cycle !== 6) begin n_bad++; $display("FAIL bp_hs_cycle: got %0d want 6", obs_hs_cycle); end
    n_cmp++; if (obs_unstable !== 1'b0) begin n_bad++; $display("FAIL bp_stable: got %b want 0", obs_unstable); end
    n_cmp++; if (obs_strb !== 4'b0110) begin n_bad++; $display("FAIL bp_strb: got %b want 0110", obs_strb); end
    n_cmp++; if (obs_done !== 8) begin n_bad++; $display("FAIL bp_done: got %0d want 8", obs_done); end
    n_cmp++; if (obs_data_at_done !== exp_data) begin n_bad++; $display("FAIL bp_data: got %h want %h", obs_data_at_done, exp_data); end
  endtask

  task automatic test_zero_store();
    predict(STORE, 4'h0, 0, 0, 1'b0, 32'h0);
    run_access(STORE, 4'h0, 32'h300, 32'h11223344, 0, 0, 1'b0, 32'h0);
    n_cmp++; if (obs_valid_cycles !== 0) begin n_bad++; $display("FAIL zero_valid: got %0d want 0", obs_valid_cycles); end
    n_cmp++; if (obs_stall_cycles !== 1) begin n_bad++; $display("FAIL zero_stall: got %0d want 1", obs_stall_cycles); end
    n_cmp++; if (obs_fault_cycles !== 0) begin n_bad++; $display("FAIL zero_fault: got %0d want 0", obs_fault_cycles); end
    n_cmp++; if (obs_data_end !== 32'h01234567) begin n_bad++; $display("FAIL zero_data_kept: got %h want 01234567", obs_data_end); end
  endtask

  task automatic test_error();
    predict(LOAD, 4'h0, 0, 1, 1'b1, 32'hFFFFFFFF);
    run_access(LOAD, 4'h0, 32'h400, 32'h0, 0, 1, 1'b1, 32'hFFFFFFFF);
    n_cmp++; if (obs_fault_cycles !== 1) begin n_bad++; $display("FAIL err_fault_pulse: got %0d want 1", obs_fault_cycles); end
    n_cmp++; if (obs_fault_at_done !== 1'b1) begin n_bad++; $display("FAIL err_fault_at_done: got %b want 1", obs_fault_at_done); end
    n_cmp++; if (obs_data_at_done !== 32'h0) begin n_bad++; $display("FAIL err_data: got %h want 0", obs_data_at_done); end
    n_cmp++; if (obs_done !== 4) begin n_bad++; $display("FAIL err_done: got %0d want 4", obs_done); end
  endtask

  task automatic test_timeout();
    // No response after a prompt handshake.
    predict(LOAD, 4'h0, 0, -1, 1'b0, 32'h0);
    run_access(LOAD, 4'h0, 32'h500, 32'h0, 0, -1, 1'b0, 32'h0);
    n_cmp++; if (obs_done !== 8) begin n_bad++; $display("FAIL to_wait_done: got %0d want 8", obs_done); end
    n_cmp++; if (obs_fault_at_done !== 1'b1) begin n_bad++; $display("FAIL to_wait_fault: got %b want 1", obs_fault_at_done); end
    n_cmp++; if (obs_data_at_done !== 32'h0) begin n_bad++; $display("FAIL to_wait_data: got %h want 0", obs_data_at_done); end
    // Never ready: request must drop at the abort and not come back.
    predict(STORE, 4'hF, -1, 0, 1'b0, 32'h0);
    run_access(STORE, 4'hF, 32'h504, 32'h55AA55AA, -1, 0, 1'b0, 32'h0);
    n_cmp++; if (obs_done !== 8) begin n_bad++; $display("FAIL to_req_done: got %0d want 8", obs_done); end
    n_cmp++; if (obs_valid_cycles !== 7) begin n_bad++; $display("FAIL to_req_valid_cycles: got %0d want 7", obs_valid_cycles); end
    // Late response after abort must be ignored.
    predict(LOAD, 4'h0, 0, 8, 1'b0, 32'h77777777);
    run_access(LOAD, 4'h0, 32'h508, 32'h0, 0, 8, 1'b0, 32'h77777777);
    n_cmp++; if (obs_data_end !== 32'h0) begin n_bad++; $display("FAIL to_late_rsp_data: got %h want 0", obs_data_end); end
    n_cmp++; if (obs_fault_cycles !== 1) begin n_bad++; $display("FAIL to_late_rsp_fault: got %0d want 1", obs_fault_cycles); end
  endtask

  task automatic test_back_to_back();
    logic        r_wr, r_err;
    logic [3:0]  r_mask, r_strb;
    logic [31:0] r_addr, r_wdata, r_rdata;
    int          r_rdy, r_rsp;
    for (int i = 0; i < 60; i++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_mask = 4'($urandom_range(0, 15));
      r_addr = $urandom; r_wdata = $urandom; r_rdata = $urandom;
      r_rdy = $urandom_range(0, 8); if (r_rdy == 8) r_rdy = -1;
      r_rsp = $urandom_range(0, 7); if (r_rsp == 7) r_rsp = -1;
      r_err = ($urandom_range(0, 4) == 0);
      r_strb = r_wr ? 4'hF : r_mask;
      predict(r_wr, r_mask, r_rdy, r_rsp, r_err, r_rdata);
      run_access(r_wr, r_mask, r_addr, r_wdata, r_rdy, r_rsp, r_err, r_rdata);
      n_cmp++; if (obs_done !== exp_done) begin n_bad++; $display("FAIL b2b[%0d] done: got %0d want %0d", i, obs_done, exp_done); end
      n_cmp++; if (obs_valid_cycles !== exp_valid_cycles) begin n_bad++; $display("FAIL b2b[%0d] valid_cycles: got %0d want %0d", i, obs_valid_cycles, exp_valid_cycles); end
      n_cmp++; if (obs_fault_at_done !== exp_fault) begin n_bad++; $display("FAIL b2b[%0d] fault: got %b want %b", i, obs_fault_at_done, exp_fault); end
      n_cmp++; if (obs_fault_cycles !== int'(exp_fault)) begin n_bad++; $display("FAIL b2b[%0d] fault_cycles: got %0d want %0d", i, obs_fault_cycles, int'(exp_fault)); end
      n_cmp++; if (obs_data_at_done !== exp_data) begin n_bad++; $display("FAIL b2b[%0d] data: got %h want %h", i, obs_data_at_done, exp_data); end
      n_cmp++; if (obs_data_end !== exp_data) begin n_bad++; $display("FAIL b2b[%0d] data_end: got %h want %h", i, obs_data_end, exp_data); end
      n_cmp++; if (obs_unstable !== 1'b0) begin n_bad++; $display("FAIL b2b[%0d] stable: got %b want 0", i, obs_unstable); end
      if (exp_valid_cycles > 0) begin
        n_cmp++; if (obs_addr !== {r_addr[31:2], 2'b00}) begin n_bad++; $display("FAIL b2b[%0d] addr: got %h want %h", i, obs_addr, {r_addr[31:2], 2'b00}); end
        n_cmp++; if (obs_strb !== r_strb) begin n_bad++; $display("FAIL b2b[%0d] strb: got %b want %b", i, obs_strb, r_strb); end
        n_cmp++; if (obs_we !== ~r_wr) begin n_bad++; $display("FAIL b2b[%0d] we: got %b want %b", i, obs_we, ~r_wr); end
        n_cmp++; if (obs_wdata !== r_wdata) begin n_bad++; $display("FAIL b2b[%0d] wdata: got %h want %h", i, obs_wdata, r_wdata); end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    cs = 1'b0; wr = LOAD; mask = 4'h0; addr = 32'h80; data_wr = 32'h0;
    bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rstw_in_wait_stall: got %b want 1", stall); end
    rst_n = 1'b0; cs = 1'b1; bus.mem_req_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hCAFEF00D; bus.mem_rsp_err = 1'b0;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rstw_idle_stall: got %b want 0", stall); end
    n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rstw_valid: got %b want 0", bus.mem_req_valid); end
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (data_rd !== 32'h0) begin n_bad++; $display("FAIL rstw_data: got %h want 0", data_rd); end
    n_cmp++; if (access_fault !== 1'b0) begin n_bad++; $display("FAIL rstw_fault: got %b want 0", access_fault); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_byte();
    test_backpressure();
    test_zero_store();
    test_error();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_mem_bridge.md
LSU_MEM_BRIDGE -- requirements
Module: lsu_mem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: the maximum number of cycles an access may spend in REQ plus WAIT before it is aborted.
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 cs  in  1  memory access request from the LSU, active-low.
REQ-005 wr  in  1  access type: 0 = store, 1 = load.
REQ-006 mask  in  4  byte-lane enables for a store.
REQ-007 addr  in  32  byte address of the access.
REQ-008 data_wr  in  32  lane-aligned store data.
REQ-009 data_rd  out  32  raw load word returned to the LSU.
REQ-010 stall  out  1  freezes the pipeline; the M-stage inputs stay stable while this is high.
REQ-011 access_fault  out  1  one-cycle pulse marking a failed or timed-out access.
REQ-012 mem_req_valid / mem_req_ready  out / in  1 / 1  bus request handshake.
REQ-013 mem_req_we  out  1  1 = write.
REQ-014 mem_req_addr  out  32  word-aligned bus address.
REQ-015 mem_req_wdata  out  32  bus write data.
REQ-016 mem_req_strb  out  4  bus byte strobes.
REQ-017 mem_rsp_valid  in  1  bus response strobe.
REQ-018 mem_rsp_rdata  in  32  bus read data.
REQ-019 mem_rsp_err  in  1  bus error flag.

Function
REQ-020 FSM states are IDLE, REQ, WAIT and DONE; reset state is IDLE.
REQ-021 IDLE with cs=0 and a non-zero access: capture wr, mask, addr and data_wr; go to REQ.
- "Non-zero access" means any load, or any store with mask != 0.
REQ-022 IDLE with cs=0, wr=0 and mask=0: go directly to DONE; no bus transaction is issued.
REQ-023 stall = (IDLE and cs=0) or REQ or WAIT.
- stall is combinational, so the requesting instruction freezes in its first cycle.
REQ-024 In REQ, mem_req_valid=1 and the captured request fields are driven, held stable until mem_req_ready=1.
- Drive: mem_req_addr = {addr[31:2],2'b00}; mem_req_we = ~wr; mem_req_strb = mask for a store, 4'b1111 for a load; mem_req_wdata = data_wr.
REQ-025 REQ with mem_req_ready=1: go to WAIT; mem_req_valid drops the next cycle.
REQ-026 mem_rsp_valid is sampled only in WAIT; responses in any other state are ignored.
REQ-027 WAIT with mem_rsp_valid=1: register mem_rsp_rdata, or 0 if mem_rsp_err=1; go to DONE.
REQ-028 DONE lasts exactly one cycle with stall=0, then goes to IDLE.
- data_rd holds the registered word until the next capture.
- access_fault=1 in DONE only if an error or timeout occurred.
REQ-029 A cycle counter clears on IDLE→REQ and increments each cycle in REQ or WAIT.
- When it reaches TIMEOUT_CYCLES-1 without completion: go to DONE, set data_rd=0 and access_fault=1.
REQ-030 A timeout in REQ deasserts mem_req_valid.
- Once abandoned, the request is not re-issued.
REQ-031 Minimum load latency is 4 cycles with ready=1 and a next-cycle response:
- IDLE(capture) → REQ → WAIT → DONE.
REQ-032 Back-to-back accesses: the IDLE cycle after DONE evaluates the next instruction's cs.
REQ-033 The low address bits are not interpreted here; lane selection and extension belong to the LSU.

Reset
REQ-034 With rst_n=0 at a rising edge:
- state=IDLE, counter=0, data_rd=0, access_fault=0, mem_req_valid=0.
- stall follows REQ-023, so it is 0 unless cs=0.
REQ-035 Reset mid-access abandons the transaction; a response arriving after reset is ignored per REQ-026.

Structure
REQ-036 A shared package holds:
- the state enum;
- the constants LOAD=1'b1 and STORE=1'b0;
- the default TIMEOUT_CYCLES.
REQ-037 No sub-module; one FSM with a datapath capture register and a timeout counter.

Verification
REQ-038 Load: addr=0x100, wr=1, cs=0, ready=1, response 0xDEADBEEF one cycle later.
- mem_req_addr=0x100, strb=1111.
- stall high for 3 cycles.
- data_rd=0xDEADBEEF in DONE.
REQ-039 Store byte: addr=0x203, mask=1000, data_wr=0xAB000000.
- mem_req_addr=0x200, we=1, strb=1000, wdata=0xAB000000.
- Completes on ack.
REQ-040 Backpressure: ready held 0 for 5 cycles.
- valid stays 1 and addr/strb/wdata stay stable throughout.
- Transfer occurs on the first ready=1.
REQ-041 Timeout: TIMEOUT_CYCLES=8, no response.
- DONE is reached 8 cycles after capture, with access_fault=1 and data_rd=0.
REQ-042 Error: mem_rsp_err=1.
- access_fault pulses for 1 cycle and data_rd=0.
- A store with mask=0 issues no mem_req_valid and stall lasts 1 cycle.
REQ-043 Reset while in WAIT, then mem_rsp_valid arrives.
- State is IDLE, the response is ignored, and data_rd stays 0.
